// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with a one-entry valid/ready output buffer.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sync1, rxs, rxs_d;
  logic          parity_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign parity_bad = (^shreg) != par_bit;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1     <= rx;
      rxs       <= sync1;
      rxs_d     <= rxs;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A pop clears valid unless a completing byte reloads it below.
      if (valid && ready)
        valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            frame_err <= !rxs;
`ifdef UART_RX_PARITY_EN
            parity_err <= parity_bad;
`endif
            if (rxs && !parity_bad) begin
              // Buffer still full and not being popped: keep the old byte.
              if (valid && !ready) begin
                overrun <= 1'b1;
              end else begin
                data_out <= shreg;
                valid    <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx (CLKS_PER_BIT=5).
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data_out;
  logic       valid, busy, frame_err, overrun, parity_err;

  uart_rx #(.CLKS_PER_BIT(5)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  int n_valid, n_ferr, n_ovr, n_perr, n_wide;
  int t_fall, lat_cyc;
  logic [7:0] last_data;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_perr = 1'b0;
  logic par_flip = 1'b0;

  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      n_valid++;
      last_data = data_out;
      if (lat_cyc < 0) lat_cyc = cyc - t_fall;
    end
    n_ferr += int'(frame_err);
    n_ovr  += int'(overrun);
    n_perr += int'(parity_err);
    if ((frame_err && prev_ferr) || (overrun && prev_ovr) || (parity_err && prev_perr))
      n_wide++;
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
    prev_perr  = parity_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
    lat_cyc = -1;
    last_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    t_fall = cyc;
    tick(5);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(5);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(5);
`endif
    rx = stop_bit;
    tick(5);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_bit;
    int         exp_valids;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 0};
    n_wide = 0;
    clear_counts();

    tick(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      clear_counts();
      send_frame(vecs[v].d, vecs[v].stop_bit);
      tick(12);
      check($sformatf("vec%0d_valids", v), n_valid, vecs[v].exp_valids);
      if (vecs[v].exp_valids > 0) begin
        check($sformatf("vec%0d_data", v), last_data, vecs[v].d);
        check($sformatf("vec%0d_latency", v), lat_cyc, 50);
      end
      check($sformatf("vec%0d_ferr", v), n_ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), n_ovr, 0);
      check($sformatf("vec%0d_idle", v), {busy, valid}, 2'b00);
    end

    // One-cycle glitch on the line
    clear_counts();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(6);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valids", n_valid, 0);
    check("glitch_ferr", n_ferr, 0);

    // Back-to-back frames with the buffer never popped
    clear_counts();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(12);
    check("ovr_data", data_out, 8'h11);
    check("ovr_valid", valid, 1'b1);
    check("ovr_count", n_ovr, 1);
    check("ovr_valids", n_valid, 1);
    ready = 1'b1;
    tick(1);
    check("ovr_pop_valid", valid, 1'b0);

    // Reset during data bit 3 of 0xFF with a byte pending
    ready = 1'b0;
    clear_counts();
    send_frame(8'h33, 1'b1);
    tick(12);
    check("pre_rst_data", data_out, 8'h33);
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(17);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    clear_counts();
    tick(40);
    check("post_rst_quiet", n_valid + n_ferr + n_ovr, 0);
    ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    tick(12);
    check("post_rst_valids", n_valid, 1);
    check("post_rst_data", last_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    tick(12);
    check("par_ok_valids", n_valid, 1);
    check("par_ok_data", last_data, 8'h07);
    check("par_ok_perr", n_perr, 0);
    clear_counts();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(12);
    par_flip = 1'b0;
    check("par_bad_perr", n_perr, 1);
    check("par_bad_valids", n_valid, 0);
`else
    check("no_parity_perr", n_perr, 0);
`endif

    check("pulse_width", n_wide, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
